// File: rtl/branch_pc_unit_pkg.sv
// Shared types and constants for the fetch-PC / branch-resolution stage.
// cond_t is also used by the data-processing stage through cond_check.
package branch_pc_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    // Bit positions inside the NZCV flag nibble
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [31:0] PIPE_OFS = 32'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/branch_pc_unit_cond_check.sv
// Combinational evaluation of an ARM condition field against NZCV flags.
module cond_check
    import branch_pc_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond_t'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch-PC owner: sequential fetch, B/BL redirect with one flush cycle,
// link-register write and saturating taken-branch counter.
module branch_pc_unit
    import branch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic [31:0]      br_pc,
    input  logic             br_link,
    input  logic [3:0]       br_cond,
    input  logic [31:0]      offset_ext,
    input  logic [3:0]       flags,
    input  logic             fetch_ready,
    output logic             fetch_req,
    output logic [31:0]      fetch_addr,
    output logic [31:0]      pc,
    output logic             flush,
    output logic             lr_we,
    output logic [31:0]      lr_data,
    output logic [CNT_W-1:0] taken_count
);

    state_t            state_q, state_d;
    logic [31:0]       pc_q;
    logic              lr_we_q;
    logic [31:0]       lr_data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cond_pass;
    logic              taken;
    logic [31:0]       target;

    cond_check u_cond_check (
        .cond  (br_cond),
        .flags (flags),
        .pass  (cond_pass)
    );

    assign taken  = (state_q == ST_FETCH) && br_valid && cond_pass;
    assign target = (br_pc + PIPE_OFS + offset_ext) & 32'hFFFF_FFFC;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (taken) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_VECTOR;
            lr_we_q   <= 1'b0;
            lr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            lr_we_q <= taken && br_link;
            // Redirect wins over an accepted sequential fetch; that fetch is flushed
            if (taken) begin
                pc_q <= target;
            end else if ((state_q == ST_FETCH) && fetch_ready) begin
                pc_q <= pc_q + PC_INC;
            end
            if (taken && br_link) begin
                lr_data_q <= br_pc + PC_INC;
            end
            if (taken && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign fetch_req   = (state_q == ST_FETCH);
    assign flush       = (state_q == ST_FLUSH);
    assign pc          = pc_q;
    assign fetch_addr  = pc_q;
    assign lr_we       = lr_we_q;
    assign lr_data     = lr_data_q;
    assign taken_count = cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed vector table, counter
// saturation sequence and randomized traffic against a reference model.
module tb_branch_pc_unit;

    localparam int unsigned TB_CNT_W = 8;
    localparam logic [31:0] TB_RV    = 32'h0000_0000;

    logic                clk = 1'b0;
    logic                reset;
    logic                br_valid;
    logic [31:0]         br_pc;
    logic                br_link;
    logic [3:0]          br_cond;
    logic [31:0]         offset_ext;
    logic [3:0]          flags;
    logic                fetch_ready;
    logic                fetch_req;
    logic [31:0]         fetch_addr;
    logic [31:0]         pc;
    logic                flush;
    logic                lr_we;
    logic [31:0]         lr_data;
    logic [TB_CNT_W-1:0] taken_count;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 = idle, 1 = fetching, 2 = bubble after redirect
    int                  m_phase;
    logic [31:0]         m_pc;
    logic                m_lr_we;
    logic [31:0]         m_lr_data;
    logic [TB_CNT_W-1:0] m_cnt;

    always #5 clk = ~clk;

    branch_pc_unit #(
        .RESET_VECTOR (TB_RV),
        .CNT_W        (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .br_valid    (br_valid),
        .br_pc       (br_pc),
        .br_link     (br_link),
        .br_cond     (br_cond),
        .offset_ext  (offset_ext),
        .flags       (flags),
        .fetch_ready (fetch_ready),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .pc          (pc),
        .flush       (flush),
        .lr_we       (lr_we),
        .lr_data     (lr_data),
        .taken_count (taken_count)
    );

    typedef struct {
        logic                rst, bv, bl;
        logic [3:0]          cond, fl;
        logic [31:0]         bpc, ofs;
        logic                fr;
        logic [31:0]         e_pc;
        logic                e_req, e_flush, e_lrwe;
        logic [31:0]         e_lrd;
        logic [TB_CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t tbl[24];

    // Condition codes pair up: odd code is the negation of the even code below it
    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc >> 1)
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cc[0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic rst, input logic bv, input logic bl, input logic [3:0] cond,
                       input logic [3:0] fl, input logic [31:0] bpc, input logic [31:0] ofs,
                       input logic fr);
        reset = rst; br_valid = bv; br_link = bl; br_cond = cond;
        flags = fl; br_pc = bpc; offset_ext = ofs; fetch_ready = fr;
        if (rst) begin
            m_phase = 0; m_pc = TB_RV; m_lr_we = 1'b0; m_lr_data = 32'h0; m_cnt = '0;
        end else begin
            m_lr_we = 1'b0;
            if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 2) begin
                m_phase = 1;
            end else if (bv && cond_ok(cond, fl)) begin
                m_pc = {bpc + 32'd8 + ofs} & ~32'd3;
                m_phase = 2;
                m_lr_we = bl;
                if (bl) m_lr_data = bpc + 32'd4;
                if (m_cnt != {TB_CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
            end else if (fr) begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        chk("model_pc", pc, m_pc);
        chk("model_fetch_addr", fetch_addr, m_pc);
        chk("model_fetch_req", 32'(fetch_req), 32'(m_phase == 1));
        chk("model_flush", 32'(flush), 32'(m_phase == 2));
        chk("model_lr_we", 32'(lr_we), 32'(m_lr_we));
        chk("model_lr_data", lr_data, m_lr_data);
        chk("model_taken_count", 32'(taken_count), 32'(m_cnt));
    endtask

    initial begin
        reset = 1'b1; br_valid = 1'b0; br_link = 1'b0; br_cond = 4'hE;
        flags = 4'h0; br_pc = 32'h0; offset_ext = 32'h0; fetch_ready = 1'b0;
        m_phase = 0; m_pc = TB_RV; m_lr_we = 1'b0; m_lr_data = 32'h0; m_cnt = '0;

        //          rst bv bl cond   flags    bpc           ofs           fr  pc            req fl we lrd         cnt
        tbl[0]  = '{1, 0, 0, 4'hE, 4'b0000, 32'h0,        32'h0,        1, 32'h0,        0, 0, 0, 32'h0,   8'd0};
        tbl[1]  = '{0, 0, 0, 4'hE, 4'b0000, 32'h0,        32'h0,        1, 32'h0,        1, 0, 0, 32'h0,   8'd0};
        tbl[2]  = '{0, 0, 0, 4'hE, 4'b0000, 32'h0,        32'h0,        1, 32'h4,        1, 0, 0, 32'h0,   8'd0};
        tbl[3]  = '{0, 0, 0, 4'hE, 4'b0000, 32'h0,        32'h0,        1, 32'h8,        1, 0, 0, 32'h0,   8'd0};
        tbl[4]  = '{0, 1, 0, 4'hE, 4'b0000, 32'h100,      32'h10,       1, 32'h118,      0, 1, 0, 32'h0,   8'd1};
        tbl[5]  = '{0, 1, 0, 4'hE, 4'b0000, 32'h200,      32'h40,       1, 32'h118,      1, 0, 0, 32'h0,   8'd1};
        tbl[6]  = '{0, 0, 0, 4'hE, 4'b0000, 32'h0,        32'h0,        0, 32'h118,      1, 0, 0, 32'h0,   8'd1};
        tbl[7]  = '{0, 1, 1, 4'hE, 4'b0000, 32'h20,       32'hFFFFFFF8, 0, 32'h20,       0, 1, 1, 32'h24,  8'd2};
        tbl[8]  = '{0, 0, 0, 4'hE, 4'b0000, 32'h0,        32'h0,        0, 32'h20,       1, 0, 0, 32'h24,  8'd2};
        tbl[9]  = '{0, 1, 0, 4'h0, 4'b0000, 32'h40,       32'h100,      1, 32'h24,       1, 0, 0, 32'h24,  8'd2};
        tbl[10] = '{0, 1, 0, 4'h0, 4'b0100, 32'h40,       32'h100,      1, 32'h148,      0, 1, 0, 32'h24,  8'd3};
        tbl[11] = '{0, 0, 0, 4'hE, 4'b0000, 32'h0,        32'h0,        1, 32'h148,      1, 0, 0, 32'h24,  8'd3};
        tbl[12] = '{0, 1, 0, 4'hE, 4'b0000, 32'hFFFFFFF8, 32'h10,       1, 32'h10,       0, 1, 0, 32'h24,  8'd4};
        tbl[13] = '{0, 0, 0, 4'hE, 4'b0000, 32'h0,        32'h0,        0, 32'h10,       1, 0, 0, 32'h24,  8'd4};
        tbl[14] = '{0, 1, 0, 4'hE, 4'b0000, 32'hFFFFFFF0, 32'h4,        1, 32'hFFFFFFFC, 0, 1, 0, 32'h24,  8'd5};
        tbl[15] = '{0, 0, 0, 4'hE, 4'b0000, 32'h0,        32'h0,        1, 32'hFFFFFFFC, 1, 0, 0, 32'h24,  8'd5};
        tbl[16] = '{0, 0, 0, 4'hE, 4'b0000, 32'h0,        32'h0,        1, 32'h0,        1, 0, 0, 32'h24,  8'd5};
        tbl[17] = '{0, 1, 0, 4'hE, 4'b0000, 32'h0,        32'h0,        1, 32'h8,        0, 1, 0, 32'h24,  8'd6};
        tbl[18] = '{1, 1, 0, 4'hE, 4'b0000, 32'h80,       32'h0,        1, 32'h0,        0, 0, 0, 32'h0,   8'd0};
        tbl[19] = '{0, 0, 0, 4'hE, 4'b0000, 32'h0,        32'h0,        1, 32'h0,        1, 0, 0, 32'h0,   8'd0};
        tbl[20] = '{0, 1, 0, 4'hF, 4'b1111, 32'h300,      32'h0,        1, 32'h4,        1, 0, 0, 32'h0,   8'd0};
        tbl[21] = '{0, 1, 0, 4'hC, 4'b1001, 32'h400,      32'h0,        1, 32'h408,      0, 1, 0, 32'h0,   8'd1};
        tbl[22] = '{0, 0, 0, 4'hE, 4'b0000, 32'h0,        32'h0,        1, 32'h408,      1, 0, 0, 32'h0,   8'd1};
        tbl[23] = '{0, 1, 1, 4'hE, 4'b0000, 32'h503,      32'h0,        1, 32'h508,      0, 1, 1, 32'h507, 8'd2};

        for (int i = 0; i < 24; i++) begin
            cyc(tbl[i].rst, tbl[i].bv, tbl[i].bl, tbl[i].cond, tbl[i].fl,
                tbl[i].bpc, tbl[i].ofs, tbl[i].fr);
            chk($sformatf("vec%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("vec%0d_fetch_addr", i), fetch_addr, tbl[i].e_pc);
            chk($sformatf("vec%0d_fetch_req", i), 32'(fetch_req), 32'(tbl[i].e_req));
            chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(tbl[i].e_flush));
            chk($sformatf("vec%0d_lr_we", i), 32'(lr_we), 32'(tbl[i].e_lrwe));
            chk($sformatf("vec%0d_lr_data", i), lr_data, tbl[i].e_lrd);
            chk($sformatf("vec%0d_taken_count", i), 32'(taken_count), 32'(tbl[i].e_cnt));
        end

        // Drive the counter well past its maximum; it must pin at all-ones
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 32'h0, 32'h0, 1'b1);
            cyc(1'b0, 1'b1, 1'b0, 4'hE, 4'h0, 32'h1000, 32'h0, 1'b1);
        end
        chk("sat_count", 32'(taken_count), 32'h0000_00FF);
        cyc(1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 4'hE, 4'h0, 32'h2000, 32'h0, 1'b1);
        chk("sat_hold", 32'(taken_count), 32'h0000_00FF);
        chk("sat_pc", pc, 32'h2008);

        cyc(1'b1, 1'b0, 1'b0, 4'hE, 4'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ofs;
            ofs = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                              : (32'($urandom_range(0, 255)) << 2);
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1), 4'($urandom), 4'($urandom),
                $urandom, ofs, ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-resolution stage that consumes the 32-bit sign-extended, word-aligned branch offset produced by the 24-bit offset extender/shifter. It owns the architectural fetch PC, drives the instruction-fetch request, evaluates the ARM condition field against NZCV, and redirects fetch on taken B/BL. It also writes the link register for BL, flushes the wrong-path pipeline and counts taken branches.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the taken-branch counter.

- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- br_valid  in  1  a decoded branch is presented this cycle.
- br_pc  in  32  address of the branch instruction.
- br_link  in  1  branch is BL.
- br_cond  in  4  ARM condition field [31:28].
- offset_ext  in  32  extender output, already shifted left 2 and sign-extended.
- flags  in  4  NZCV, bit 3 = N … bit 0 = V.
- fetch_ready  in  1  instruction memory accepts fetch_addr this cycle.
- fetch_req  out  1  fetch request.
- fetch_addr  out  32  fetch address, equals pc.
- pc  out  32  current fetch PC.
- flush  out  1  one-cycle kill of fetch/decode contents.
- lr_we  out  1  link-register write strobe.
- lr_data  out  32  link value.
- taken_count  out  CNT_W  saturating count of taken branches.

## Operation
- FSM states: IDLE, FETCH, FLUSH.
  - IDLE: entered on reset; leaves for FETCH unconditionally on the next cycle.
  - FETCH: fetch_req=1.
  - FLUSH: fetch_req=0, lasts exactly one cycle, then returns to FETCH.
- Fetch address handling:
  - fetch_addr is sampled by memory only when fetch_ready=1.
  - fetch_addr may change while fetch_req=1 and fetch_ready=0. A redirect replaces an unaccepted request.
- FETCH, fetch_ready=1, no taken branch: pc <= pc+4.
- Condition evaluation (combinational, cond_pass):
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z.
  - GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1, NV (4'hF) 0.
- Taken branch = state FETCH & br_valid & cond_pass.
  - pc <= target, where target = br_pc + 8 + offset_ext, modulo 2^32, with bits [1:0] forced to 0.
  - State moves to FLUSH.
  - flush=1 during the FLUSH cycle.
  - taken_count increments and saturates at all-ones.
- A taken branch has priority over a simultaneous fetch_ready increment. The accepted fetch is wrong-path and is covered by the flush.
- BL taken: lr_we=1 and lr_data=br_pc+4 in the FLUSH cycle.
- br_valid is ignored in IDLE and FLUSH: no redirect, no LR write, no count.
- A not-taken branch has no side effects.

## Timing
- Reset values:
  - pc=RESET_VECTOR, state=IDLE.
  - fetch_req=0, flush=0, lr_we=0, lr_data=0, taken_count=0.
- Reset asserted mid-operation: all of the above take effect at the next edge. A pending redirect is lost.
- Outputs are registered or state-decoded; no combinational path from br_* to fetch_req or flush. fetch_addr tracks the pc register.
- Redirect latency:
  - Branch presented in cycle N → pc=target from cycle N+1.
  - flush and lr_we asserted in cycle N+1.
  - fetch_req=0 in N+1 and returns to 1 in N+2 with fetch_addr=target.
- Throughput: one sequential fetch per cycle while fetch_ready=1. Branch penalty is one bubble cycle plus the flushed instructions.
- Wrap-around: pc+4 and target both wrap modulo 2^32 with no error.

## Structure
- Shared package holds:
  - the cond_t enum (EQ…NV, 4 bits);
  - NZCV bit-index constants;
  - PC_INC=4 and PIPE_OFS=8;
  - the state enum.
- Sub-module cond_check is natural: inputs cond and flags, output pass. It is purely combinational and reused by the data-processing stage.
- The remainder is a single module.

## Test plan
- Reset released, fetch_ready held 1 → fetch_addr = 0x0, 0x4, 0x8 on successive cycles.
- br_pc=0x100, offset_ext=0x10, br_cond=AL, br_valid=1 → next cycle pc=0x118, flush=1, fetch_req=0. Following cycle fetch_addr=0x118. taken_count=1.
- BL with br_pc=0x20, offset_ext=0xFFFFFFF8 → target 0x20, lr_we=1, lr_data=0x24.
- br_cond=EQ with flags Z=0 → no flush, pc continues +4. Same branch with Z=1 → taken.
- Wrap: br_pc=0xFFFFFFF8, offset_ext=0x10 → pc=0x10. Sequential pc=0xFFFFFFFC with fetch_ready=1 → 0x0.
- br_valid during FLUSH → ignored. Reset asserted in the FLUSH cycle → pc=RESET_VECTOR, flush=0 at the next edge. taken_count preset to 0xFFFF plus a taken branch → stays 0xFFFF.
